// File: rtl/rv_mem_pkg.sv
// Shared types for the L1-to-memory arbitration path: arbiter FSM states and grant owner.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Grant FSM for the I/D cache arbiter: request seen in IDLE -> SERVE next cycle, IDLE bubble after each resp.
// Holds the grant until mem_resp; ties go to the side not served last.
module cache_arbiter_control
  import rv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       mem_resp,
  output arb_state_t state,
  output logic       busy
);

  arb_state_t state_nxt;
  grant_t     last_grant;
  grant_t     last_grant_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        // mem_resp is deliberately ignored here: a stray completion must not move the FSM
        if (i_req && d_req) begin
          state_nxt = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
        end else if (i_req) begin
          state_nxt = SERVE_I;
        end else if (d_req) begin
          state_nxt = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_D;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port; strobes appear one cycle after the request.
// No data storage: strobes and resps are pure muxes on the granted side, mem_rdata is broadcast.
module cache_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  arb_state_t state;

  cache_arbiter_control u_control (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_read),
    .d_req    (d_read | d_write),
    .mem_resp (mem_resp),
    .state    (state),
    .busy     (busy)
  );

  // Address/wdata default to the D side so only one mux leg is needed; they are don't-care in IDLE.
  always_comb begin
    mem_address = d_address;
    mem_wdata   = d_wdata;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (state)
      SERVE_I: begin
        mem_address = i_address;
        mem_read    = i_read;
        i_resp      = mem_resp;
      end
      SERVE_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  a_d_read_write_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have I-side ports:
- i_address  input  ADDR_W  I-cache line address
- i_read  input  1  I-cache line read request
- i_rdata  output  LINE_W  line read data to I-cache
- i_resp  output  1  I-cache completion pulse
REQ-006 SHALL have D-side ports:
- d_address  input  ADDR_W  D-cache line address
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write request
- d_wdata  input  LINE_W  D-cache write data
- d_rdata  output  LINE_W  line read data to D-cache
- d_resp  output  1  D-cache completion pulse
REQ-007 SHALL have downstream ports to the eviction write buffer:
- mem_address  output  ADDR_W  address
- mem_read  output  1  read strobe
- mem_write  output  1  write strobe
- mem_wdata  output  LINE_W  write data
- mem_rdata  input  LINE_W  read data
- mem_resp  input  1  completion
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement an FSM with states IDLE, SERVE_I and SERVE_D.
REQ-010 SHALL treat requesters as level-held: a request stays asserted, with stable address and data, until its resp.
REQ-011 In IDLE, SHALL drive mem_read=0 and mem_write=0, with mem_address and mem_wdata don't-care.
REQ-012 In IDLE, with exactly one pending requester (I: i_read; D: d_read|d_write), SHALL transition next cycle to that requester's SERVE state.
REQ-013 In IDLE, with both pending, SHALL grant the requester not served last, tracked by a 1-bit last_grant register; after reset last_grant=I, so D wins the first tie.
REQ-014 In SERVE_I, SHALL combinationally drive mem_address=i_address, mem_read=i_read, mem_write=0.
REQ-015 In SERVE_D, SHALL combinationally drive mem_address=d_address, mem_read=d_read, mem_write=d_write and mem_wdata=d_wdata.
REQ-016 SHALL broadcast mem_rdata to both i_rdata and d_rdata unconditionally.
REQ-017 SHALL set i_resp = mem_resp & SERVE_I and d_resp = mem_resp & SERVE_D; a resp is never asserted to a requester that is not granted.
REQ-018 On mem_resp in a SERVE state, SHALL return to IDLE next cycle and update last_grant to the served side.
REQ-019 Minimum latency SHALL be request seen in IDLE at cycle N, mem strobe asserted at N+1, and a mandatory one-cycle IDLE bubble between back-to-back grants.
REQ-020 SHALL hold a grant until mem_resp even if the granted requester drops its request, which is a protocol violation; the strobe then follows the input and may drop.
REQ-021 If d_read and d_write are asserted together (illegal), SHALL forward both unchanged; a simulation assertion SHALL flag the condition.
REQ-022 SHALL ignore mem_resp while in IDLE, with no state change and no resp pulse.
REQ-023 SHALL not preempt: a request arriving during SERVE_x waits until IDLE.

Reset
REQ-024 While rst_n=0, SHALL force state=IDLE, last_grant=I, busy=0, mem_read=0, mem_write=0, i_resp=0 and d_resp=0, independent of clk.
REQ-025 On reset assertion mid-transaction, SHALL abandon the in-flight downstream request without completion, emitting no resp.
REQ-026 After rst_n deasserts, SHALL evaluate requests in IDLE on the first rising clk edge.

Structure
REQ-027 SHALL define the FSM state enum arb_state_t {IDLE, SERVE_I, SERVE_D} and the grant_t {GRANT_I, GRANT_D} typedef in shared package rv_mem_pkg.
REQ-028 SHALL split the FSM and last_grant register into sub-module cache_arbiter_control; the top level contains only the output muxing.
REQ-029 SHALL contain no data-path registers; LINE_W data is never stored.

Verification
REQ-030 D-only read: d_read=1, d_address=0x0000_1000, mem_resp after 3 cycles with mem_rdata=0xA5..A5 -> mem_read rises cycle 1, d_resp=1 for 1 cycle, d_rdata=0xA5..A5, i_resp stays 0.
REQ-031 Simultaneous requests from reset: i_read=1 at 0x0000_0040 and d_write=1 at 0x0000_2000 in the same cycle -> D served first with mem_write=1 and mem_address=0x0000_2000, then one IDLE bubble, then I with mem_read=1 and mem_address=0x0000_0040.
REQ-032 Fairness under continuous contention: both held, with 4 responses -> grant order D,I,D,I and busy low exactly one cycle between each.
REQ-033 Stray response: mem_resp=1 while IDLE -> no state change, i_resp=0, d_resp=0.
REQ-034 Reset mid-op: rst_n=0 two cycles into SERVE_I -> mem_read=0 immediately (asynchronous), busy=0, no i_resp; after release with i_read still high -> re-granted one cycle later.
REQ-035 Late arrival: i_read asserted during SERVE_D -> no mem_address change until d_resp, then SERVE_I after the IDLE bubble.
